tour_cmd: RTL and testbench

Command issuer for the knight's tour. Sits between the UART command wrapper, the tour solver's move memory and the command processor. When idle it passes host commands straight through. During a tour it becomes the initiator on the cmd/cmd_rdy/clr_cmd_rdy/send_resp interface, and turns each solved knight move into two single-axis move commands.

---
 rtl/tour_cmd.sv | 56 +++++
 tb/tb_tour_cmd.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tour_cmd.sv
`timescale 1ns/1ps
// tour_cmd: knight's-tour command issuer; passes UART commands through when idle
module tour_cmd #(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);
  typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;
  state_t state, nxt;
  logic last;
  logic [15:0] vert, horz;
  assign last = mv_indx == 5'(NUM_MOVES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) mv_indx <= '0;
    else if (state == IDLE && start_tour) mv_indx <= '0;
    else if (state == WAIT_H && send_resp && !last) mv_indx <= mv_indx + 5'd1;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start_tour) nxt = VERT;
      VERT:    if (move == '0) nxt = IDLE; else if (clr_cmd_rdy) nxt = WAIT_V;
      WAIT_V:  if (send_resp) nxt = HORZ;
      HORZ:    if (clr_cmd_rdy) nxt = WAIT_H;
      WAIT_H:  if (send_resp) nxt = last ? IDLE : VERT;
      default: nxt = IDLE;
    endcase
  end
  // legs decoded from the lowest set bit of move
  always_comb begin
    vert = (move[0] | move[1]) ? 16'h2002 : move[2] ? 16'h2001 : move[3] ? 16'h27F1 :
           (move[4] | move[5]) ? 16'h27F2 : move[6] ? 16'h27F1 : 16'h2001;
    horz = move[0] ? 16'h33F1 : move[1] ? 16'h3BF1 : (move[2] | move[3]) ? 16'h33F2 :
           move[4] ? 16'h33F1 : move[5] ? 16'h3BF1 : 16'h3BF2;
  end
  always_comb begin
    cmd = state == IDLE ? cmd_UART : (state == VERT || state == WAIT_V) ? vert : horz;
    cmd_rdy = state == IDLE ? cmd_rdy_UART : (state == VERT && move != '0) || state == HORZ;
    clr_cmd_rdy_UART = state == IDLE && clr_cmd_rdy;
    resp = (state == IDLE || (state == WAIT_H && last)) ? 8'hA5 : 8'h5A;
  end
endmodule

// File: tb/tb_tour_cmd.sv
`timescale 1ns/1ps
// tb_tour_cmd: directed scenario bench for tour_cmd
module tb_tour_cmd;
  logic clk = 0, rst = 1, start_tour = 0, cmd_rdy_UART = 0, clr_cmd_rdy = 0, send_resp = 0;
  logic [15:0] cmd_UART = 16'h0;
  logic [7:0] mem [32];
  logic [7:0] move, move_one;
  logic [4:0] mv_indx, one_idx;
  logic clr_cmd_rdy_UART, cmd_rdy, one_clr, one_rdy;
  logic [15:0] cmd, one_cmd;
  logic [7:0] resp, one_resp;
  int errors = 0, checks = 0;
  logic [15:0] ev [8] = '{16'h2002, 16'h2002, 16'h2001, 16'h27F1, 16'h27F2, 16'h27F2, 16'h27F1, 16'h2001};
  logic [15:0] eh [8] = '{16'h33F1, 16'h3BF1, 16'h33F2, 16'h33F2, 16'h33F1, 16'h3BF1, 16'h3BF2, 16'h3BF2};

  always #5 clk = ~clk;
  assign move = mem[mv_indx];
  assign move_one = 8'h01;

  tour_cmd u_dut (.clk(clk), .rst(rst), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp));

  tour_cmd #(.NUM_MOVES(1)) u_one (.clk(clk), .rst(rst), .start_tour(start_tour), .move(move_one),
    .mv_indx(one_idx), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(one_clr),
    .cmd(one_cmd), .cmd_rdy(one_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(one_resp));

  function automatic logic [15:0] leg(input logic [7:0] m, input bit h);
    logic [15:0] r = 16'h0;
    for (int b = 7; b >= 0; b--) if (m[b]) r = h ? eh[b] : ev[b];
    return r;
  endfunction

  task automatic idle_cycle; @(negedge clk); #1; endtask
  task automatic clr_pulse; clr_cmd_rdy = 1; @(negedge clk); clr_cmd_rdy = 0; #1; endtask
  task automatic send_pulse; send_resp = 1; @(negedge clk); send_resp = 0; #1; endtask
  task automatic start_pulse; start_tour = 1; @(negedge clk); start_tour = 0; #1; endtask
  task automatic run_move; clr_pulse; send_pulse; clr_pulse; send_pulse; endtask

  task automatic test_reset;
    cmd_UART = 16'h1234; cmd_rdy_UART = 1; #1;
    checks++; if (mv_indx !== 5'd0) begin errors++; $display("FAIL reset_idx got=%h exp=0", mv_indx); end
    checks++; if (cmd !== 16'h1234) begin errors++; $display("FAIL reset_cmd got=%h exp=1234", cmd); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%b exp=1", cmd_rdy); end
    checks++; if (resp !== 8'hA5) begin errors++; $display("FAIL reset_resp got=%h exp=a5", resp); end
    checks++; if (clr_cmd_rdy_UART !== 1'b0) begin errors++; $display("FAIL reset_clr got=%b exp=0", clr_cmd_rdy_UART); end
    idle_cycle; rst = 0; idle_cycle;
  endtask

  task automatic test_passthrough;
    cmd_UART = 16'h0000; cmd_rdy_UART = 1; #1;
    checks++; if (cmd !== 16'h0000) begin errors++; $display("FAIL pt_cmd got=%h exp=0000", cmd); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL pt_rdy got=%b exp=1", cmd_rdy); end
    clr_cmd_rdy = 1; #1;
    checks++; if (clr_cmd_rdy_UART !== 1'b1) begin errors++; $display("FAIL pt_clr_hi got=%b exp=1", clr_cmd_rdy_UART); end
    @(negedge clk); clr_cmd_rdy = 0; #1;
    checks++; if (clr_cmd_rdy_UART !== 1'b0) begin errors++; $display("FAIL pt_clr_lo got=%b exp=0", clr_cmd_rdy_UART); end
    send_resp = 1; #1;
    checks++; if (resp !== 8'hA5) begin errors++; $display("FAIL pt_resp got=%h exp=a5", resp); end
    @(negedge clk); send_resp = 0; cmd_UART = 16'hC3A1; #1;
    checks++; if (cmd !== 16'hC3A1) begin errors++; $display("FAIL pt_cmd2 got=%h exp=c3a1", cmd); end
    cmd_rdy_UART = 0; idle_cycle;
  endtask

  task automatic test_single_move;
    mem[0] = 8'h01; mem[1] = 8'h00;
    start_pulse;
    checks++; if (one_cmd !== 16'h2002 || one_rdy !== 1'b1) begin errors++; $display("FAIL single_v got=%h/%b exp=2002/1", one_cmd, one_rdy); end
    clr_pulse;
    checks++; if (one_rdy !== 1'b0 || one_cmd !== 16'h2002) begin errors++; $display("FAIL single_wv got=%h/%b exp=2002/0", one_cmd, one_rdy); end
    send_resp = 1; #1;
    checks++; if (one_resp !== 8'h5A) begin errors++; $display("FAIL single_resp1 got=%h exp=5a", one_resp); end
    @(negedge clk); send_resp = 0; #1;
    checks++; if (one_cmd !== 16'h33F1 || one_rdy !== 1'b1) begin errors++; $display("FAIL single_h got=%h/%b exp=33f1/1", one_cmd, one_rdy); end
    clr_pulse;
    send_resp = 1; #1;
    checks++; if (one_resp !== 8'hA5) begin errors++; $display("FAIL single_resp2 got=%h exp=a5", one_resp); end
    @(negedge clk); send_resp = 0; #1;
    checks++; if (one_rdy !== 1'b0 || one_cmd !== cmd_UART) begin errors++; $display("FAIL single_idle got=%h/%b exp=%h/0", one_cmd, one_rdy, cmd_UART); end
    checks++; if (cmd_rdy !== 1'b0 || mv_indx !== 5'd1) begin errors++; $display("FAIL single_zero got=%b/%0d exp=0/1", cmd_rdy, mv_indx); end
    idle_cycle;
  endtask

  task automatic test_all_moves;
    for (int i = 0; i < 8; i++) mem[i] = 8'h01 << i;
    mem[8] = 8'h00;
    start_pulse;
    for (int i = 0; i < 8; i++) begin
      checks++; if (cmd !== ev[i] || cmd_rdy !== 1'b1) begin errors++; $display("FAIL all_v%0d got=%h/%b exp=%h/1", i, cmd, cmd_rdy, ev[i]); end
      checks++; if (mv_indx !== 5'(i)) begin errors++; $display("FAIL all_idx%0d got=%0d exp=%0d", i, mv_indx, i); end
      clr_pulse;
      checks++; if (cmd !== ev[i] || cmd_rdy !== 1'b0) begin errors++; $display("FAIL all_wv%0d got=%h/%b exp=%h/0", i, cmd, cmd_rdy, ev[i]); end
      send_resp = 1; #1;
      checks++; if (resp !== 8'h5A) begin errors++; $display("FAIL all_rv%0d got=%h exp=5a", i, resp); end
      @(negedge clk); send_resp = 0; #1;
      checks++; if (cmd !== eh[i] || cmd_rdy !== 1'b1) begin errors++; $display("FAIL all_h%0d got=%h/%b exp=%h/1", i, cmd, cmd_rdy, eh[i]); end
      clr_pulse;
      send_resp = 1; #1;
      checks++; if (resp !== 8'h5A) begin errors++; $display("FAIL all_rh%0d got=%h exp=5a", i, resp); end
      @(negedge clk); send_resp = 0; #1;
    end
    checks++; if (mv_indx !== 5'd8 || cmd_rdy !== 1'b0) begin errors++; $display("FAIL all_end got=%0d/%b exp=8/0", mv_indx, cmd_rdy); end
    idle_cycle;
    checks++; if (resp !== 8'hA5) begin errors++; $display("FAIL all_idle got=%h exp=a5", resp); end
  endtask

  task automatic test_boundary;
    mem[0] = 8'h01; mem[1] = 8'hA4; mem[2] = 8'h00;
    start_pulse;
    send_pulse;
    checks++; if (cmd !== 16'h2002 || cmd_rdy !== 1'b1) begin errors++; $display("FAIL bnd_send_vert got=%h/%b exp=2002/1", cmd, cmd_rdy); end
    clr_cmd_rdy = 1; send_resp = 1; @(negedge clk); clr_cmd_rdy = 0; send_resp = 0; #1;
    checks++; if (cmd_rdy !== 1'b0 || cmd !== 16'h2002) begin errors++; $display("FAIL bnd_both got=%h/%b exp=2002/0", cmd, cmd_rdy); end
    idle_cycle;
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL bnd_stay_wv got=%b exp=0", cmd_rdy); end
    clr_pulse;
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL bnd_clr_wv got=%b exp=0", cmd_rdy); end
    send_pulse;
    start_pulse;
    checks++; if (cmd !== 16'h33F1 || cmd_rdy !== 1'b1 || mv_indx !== 5'd0) begin errors++; $display("FAIL bnd_start_horz got=%h/%b/%0d exp=33f1/1/0", cmd, cmd_rdy, mv_indx); end
    clr_pulse; send_pulse;
    checks++; if (cmd !== 16'h2001 || mv_indx !== 5'd1) begin errors++; $display("FAIL bnd_multi_v got=%h/%0d exp=2001/1", cmd, mv_indx); end
    clr_pulse; send_pulse;
    checks++; if (cmd !== 16'h33F2) begin errors++; $display("FAIL bnd_multi_h got=%h exp=33f2", cmd); end
    clr_pulse; send_pulse;
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL bnd_zero got=%b exp=0", cmd_rdy); end
    idle_cycle;
    checks++; if (resp !== 8'hA5 || mv_indx !== 5'd2) begin errors++; $display("FAIL bnd_idle got=%h/%0d exp=a5/2", resp, mv_indx); end
  endtask

  task automatic test_zero_move;
    mem[0] = 8'h04; mem[1] = 8'h08; mem[2] = 8'h40; mem[3] = 8'h00;
    start_pulse;
    run_move; run_move; run_move;
    checks++; if (mv_indx !== 5'd3 || cmd_rdy !== 1'b0) begin errors++; $display("FAIL zero_vert got=%0d/%b exp=3/0", mv_indx, cmd_rdy); end
    idle_cycle;
    checks++; if (resp !== 8'hA5 || cmd_rdy !== 1'b0) begin errors++; $display("FAIL zero_idle got=%h/%b exp=a5/0", resp, cmd_rdy); end
  endtask

  task automatic test_host_reset;
    mem[0] = 8'h10; mem[1] = 8'h00;
    start_pulse;
    clr_pulse;
    cmd_UART = 16'hBEEF; cmd_rdy_UART = 1; clr_cmd_rdy = 1; #1;
    checks++; if (clr_cmd_rdy_UART !== 1'b0) begin errors++; $display("FAIL host_clr got=%b exp=0", clr_cmd_rdy_UART); end
    checks++; if (cmd !== 16'h27F2 || cmd_rdy !== 1'b0) begin errors++; $display("FAIL host_cmd got=%h/%b exp=27f2/0", cmd, cmd_rdy); end
    @(negedge clk); clr_cmd_rdy = 0; #1;
    send_pulse;
    checks++; if (cmd !== 16'h33F1 || cmd_rdy !== 1'b1) begin errors++; $display("FAIL host_horz got=%h/%b exp=33f1/1", cmd, cmd_rdy); end
    rst = 1; #1;
    checks++; if (mv_indx !== 5'd0 || cmd_rdy !== 1'b1 || cmd !== 16'hBEEF || resp !== 8'hA5) begin errors++; $display("FAIL rst_mid got=%0d/%b/%h/%h exp=0/1/beef/a5", mv_indx, cmd_rdy, cmd, resp); end
    @(negedge clk); rst = 0; #1;
    clr_cmd_rdy = 1; #1;
    checks++; if (clr_cmd_rdy_UART !== 1'b1) begin errors++; $display("FAIL host_after got=%b exp=1", clr_cmd_rdy_UART); end
    @(negedge clk); clr_cmd_rdy = 0; cmd_rdy_UART = 0; #1;
  endtask

  task automatic test_full_tour;
    int n = 0, cyc = 0, d;
    bit done = 0;
    logic [7:0] last_resp = 8'h00;
    for (int i = 0; i < 24; i++) mem[i] = 8'h01 << $urandom_range(7, 0);
    start_pulse;
    while (cyc < 6000 && !done) begin
      if (cmd_rdy) begin
        checks++; if (cmd !== leg(mem[n / 2], n[0])) begin errors++; $display("FAIL tour_cmd%0d got=%h exp=%h", n, cmd, leg(mem[n / 2], n[0])); end
        n++;
        clr_pulse;
        d = $urandom_range(50, 1);
        repeat (d - 1) idle_cycle;
        send_resp = 1; #1;
        last_resp = resp;
        if (n < 48) begin
          checks++; if (resp !== 8'h5A) begin errors++; $display("FAIL tour_resp%0d got=%h exp=5a", n, resp); end
        end
        @(negedge clk); send_resp = 0; #1;
        cyc += d + 1;
        done = n == 48;
      end else begin
        idle_cycle;
        cyc++;
      end
    end
    checks++; if (n != 48) begin errors++; $display("FAIL tour_count got=%0d exp=48", n); end
    checks++; if (last_resp !== 8'hA5) begin errors++; $display("FAIL tour_last_resp got=%h exp=a5", last_resp); end
    checks++; if (mv_indx !== 5'd23) begin errors++; $display("FAIL tour_idx got=%0d exp=23", mv_indx); end
    idle_cycle;
    checks++; if (cmd_rdy !== 1'b0 || resp !== 8'hA5) begin errors++; $display("FAIL tour_idle got=%b/%h exp=0/a5", cmd_rdy, resp); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    test_reset;
    test_passthrough;
    test_single_move;
    test_all_moves;
    test_boundary;
    test_zero_move;
    test_host_reset;
    test_full_tour;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
